nal_stream_parser: RTL and testbench

Synthesisable successor to the bench-only bitstream loader. Accepts a raw HEVC Annex-B byte stream and detects start codes, both 00 00 01 and 00 00 00 01. Strips start codes, trailing zeros and (optionally) emulation-prevention bytes. Emits NAL-unit bytes with sop/eop/type tags through a buffered valid/ready interface to the CABAC/bitstream front end, for any number of NAL units, with a type filter.

---
 rtl/nal_pkg.sv | 30 +++
 rtl/nal_sync_fifo.sv | 73 +++++++
 rtl/nal_stream_parser.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_nal_stream_parser.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nal_pkg.sv
// Shared types and constants for the HEVC Annex-B NAL stream parser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nal_pkg;

    // Parser states.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        FLUSH   = 2'd3
    } nal_state_t;

    localparam logic [7:0] SC_BYTE  = 8'h01;
    localparam logic [7:0] EPB_BYTE = 8'h03;

    // HEVC parameter-set NAL unit types.
    localparam logic [5:0] NAL_VPS = 6'd32;
    localparam logic [5:0] NAL_SPS = 6'd33;
    localparam logic [5:0] NAL_PPS = 6'd34;

    // One output beat: NAL byte plus framing tags.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [5:0] nal_type;
        logic [7:0] data;
    } nal_beat_t;

endpackage

// File: rtl/nal_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Latency: a pushed word is readable the cycle after the push.
// Backpressure: pushes ignored while full, pops ignored while empty.
//
// Ports: clk, rst_n; push_vld/push_dat/full (write side);
//        pop_rdy/pop_dat/empty (read side, pop_dat is the head word).
module nal_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_vld && !full_q;
        do_pop   = pop_rdy && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
        // Flags come from the next count so they are plain flops.
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign pop_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/nal_stream_parser.sv
// Annex-B byte stream to tagged NAL bytes: strips start codes, trailing zeros, EPBs; filters by type.
// Latency: >=2 cycles from byte acceptance to out_data (tail register plus FIFO).
// Backpressure: in_rdy drops when the output FIFO is full or zeros are being flushed.
//
// Ports: clk, rst_n; in_data/in_vld/in_last/in_rdy (stream in);
//        out_data/out_vld/out_rdy/out_sop/out_eop/out_type (NAL out);
//        nal_count, epb_count, err (sticky), done (pulse after in_last).
module nal_stream_parser
    import nal_pkg::*;
#(
    parameter bit          EPB_REMOVE = 1'b1,
    parameter logic [63:0] TYPE_MASK  = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          FIFO_DEPTH = 8,
    parameter int          ZCNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic        in_last,
    output logic        in_rdy,
    output logic [7:0]  out_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        out_sop,
    output logic        out_eop,
    output logic [5:0]  out_type,
    output logic [15:0] nal_count,
    output logic [15:0] epb_count,
    output logic        err,
    output logic        done
);
    localparam int BEAT_W = $bits(nal_beat_t);

    nal_state_t        state_q, state_d;
    logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
    logic              keep_q, keep_d;
    logic [5:0]        type_q, type_d;
    nal_beat_t         tail_q, tail_d;
    logic              tail_vld_q, tail_vld_d;
    logic [7:0]        park_q, park_d;
    logic              park_vld_q, park_vld_d;
    logic              park_drop_q, park_drop_d;
    logic              park_last_q, park_last_d;
    logic [15:0]       nal_cnt_q, nal_cnt_d;
    logic [15:0]       epb_cnt_q, epb_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              run_q;

    logic              accept;
    logic              zge2, zge3;
    logic [ZCNT_W-1:0] zcnt_inc;
    logic              push_req, push_eop, push_vld;
    nal_beat_t         push_dat, pop_dat;
    logic              fifo_full, fifo_empty;

    // in_rdy depends only on flops, so out_rdy never reaches it combinationally.
    assign in_rdy = run_q && !fifo_full && (state_q != FLUSH);
    assign accept = in_vld && in_rdy;

    always_comb begin
        zge2     = (zcnt_q >= ZCNT_W'(2));
        zge3     = (zcnt_q >= ZCNT_W'(3));
        zcnt_inc = (zcnt_q == '1) ? zcnt_q : zcnt_q + ZCNT_W'(1);

        state_d     = state_q;
        zcnt_d      = zcnt_q;
        keep_d      = keep_q;
        type_d      = type_q;
        tail_d      = tail_q;
        tail_vld_d  = tail_vld_q;
        park_d      = park_q;
        park_vld_d  = park_vld_q;
        park_drop_d = park_drop_q;
        park_last_d = park_last_q;
        nal_cnt_d   = nal_cnt_q;
        epb_cnt_d   = epb_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        push_req    = 1'b0;
        push_eop    = 1'b0;

        case (state_q)
            SEARCH: begin
                if (accept) begin
                    if (in_last) begin
                        done_d = 1'b1;
                        zcnt_d = '0;
                    end else if (in_data == 8'h00) begin
                        zcnt_d = zcnt_inc;
                    end else if (in_data == SC_BYTE && zge2) begin
                        state_d = HDR;
                        zcnt_d  = '0;
                    end else begin
                        zcnt_d = '0;
                    end
                end
            end

            HDR: begin
                if (accept) begin
                    if (in_last) begin
                        // A header with nothing after it is not emitted.
                        done_d  = 1'b1;
                        state_d = SEARCH;
                        zcnt_d  = '0;
                    end else begin
                        type_d          = in_data[6:1];
                        keep_d          = TYPE_MASK[in_data[6:1]];
                        tail_d.sop      = 1'b1;
                        tail_d.eop      = 1'b0;
                        tail_d.nal_type = in_data[6:1];
                        tail_d.data     = in_data;
                        tail_vld_d      = 1'b1;
                        state_d         = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        if (in_last) begin
                            // Pending zeros at end of stream are trailing zeros.
                            push_req   = 1'b1;
                            push_eop   = 1'b1;
                            tail_vld_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = SEARCH;
                            zcnt_d     = '0;
                        end else begin
                            zcnt_d = zcnt_inc;
                        end
                    end else if (in_data == SC_BYTE && zge2) begin
                        push_req   = 1'b1;
                        push_eop   = 1'b1;
                        tail_vld_d = 1'b0;
                        zcnt_d     = '0;
                        if (in_last) begin
                            done_d  = 1'b1;
                            state_d = SEARCH;
                        end else begin
                            state_d = HDR;
                        end
                    end else begin
                        if (zge3) begin
                            err_d = 1'b1;
                        end
                        if (zcnt_q != '0) begin
                            // Park the byte; FLUSH emits the held zeros first.
                            state_d     = FLUSH;
                            park_d      = in_data;
                            park_vld_d  = 1'b1;
                            park_last_d = in_last;
                            park_drop_d = EPB_REMOVE && (in_data == EPB_BYTE) && zge2;
                            if (EPB_REMOVE && (in_data == EPB_BYTE) && zge2) begin
                                epb_cnt_d = epb_cnt_q + 16'd1;
                            end
                        end else begin
                            push_req        = 1'b1;
                            tail_d.sop      = 1'b0;
                            tail_d.eop      = 1'b0;
                            tail_d.nal_type = type_q;
                            tail_d.data     = in_data;
                            if (in_last) begin
                                // Closing push needs its own cycle.
                                state_d     = FLUSH;
                                park_vld_d  = 1'b0;
                                park_last_d = 1'b1;
                            end
                        end
                    end
                end
            end

            FLUSH: begin
                if (!fifo_full) begin
                    if (zcnt_q != '0) begin
                        push_req        = 1'b1;
                        tail_d.sop      = 1'b0;
                        tail_d.eop      = 1'b0;
                        tail_d.nal_type = type_q;
                        tail_d.data     = 8'h00;
                        zcnt_d          = zcnt_q - ZCNT_W'(1);
                    end else if (park_vld_q) begin
                        park_vld_d = 1'b0;
                        if (!park_drop_q) begin
                            push_req        = 1'b1;
                            tail_d.sop      = 1'b0;
                            tail_d.eop      = 1'b0;
                            tail_d.nal_type = type_q;
                            tail_d.data     = park_q;
                        end
                        if (!park_last_q) begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        // End of stream: close the NAL with the tail byte.
                        push_req    = 1'b1;
                        push_eop    = 1'b1;
                        tail_vld_d  = 1'b0;
                        park_last_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = SEARCH;
                        zcnt_d      = '0;
                    end
                end
            end

            default: state_d = SEARCH;
        endcase

        // Dropped NALs still walk the FSM but never reach the FIFO.
        push_vld     = push_req && keep_q && tail_vld_q;
        push_dat     = tail_q;
        push_dat.eop = push_eop;
        if (push_vld && push_eop) begin
            nal_cnt_d = nal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            zcnt_q      <= '0;
            keep_q      <= 1'b0;
            type_q      <= '0;
            tail_q      <= '0;
            tail_vld_q  <= 1'b0;
            park_q      <= '0;
            park_vld_q  <= 1'b0;
            park_drop_q <= 1'b0;
            park_last_q <= 1'b0;
            nal_cnt_q   <= '0;
            epb_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            zcnt_q      <= zcnt_d;
            keep_q      <= keep_d;
            type_q      <= type_d;
            tail_q      <= tail_d;
            tail_vld_q  <= tail_vld_d;
            park_q      <= park_d;
            park_vld_q  <= park_vld_d;
            park_drop_q <= park_drop_d;
            park_last_q <= park_last_d;
            nal_cnt_q   <= nal_cnt_d;
            epb_cnt_q   <= epb_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            run_q       <= 1'b1;
        end
    end

    nal_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop_rdy  (out_rdy),
        .pop_dat  (pop_dat),
        .empty    (fifo_empty)
    );

    // Outputs read as zero when nothing is valid (storage is not reset).
    assign out_vld   = !fifo_empty;
    assign out_data  = out_vld ? pop_dat.data : 8'h00;
    assign out_sop   = out_vld && pop_dat.sop;
    assign out_eop   = out_vld && pop_dat.eop;
    assign out_type  = out_vld ? pop_dat.nal_type : 6'd0;
    assign nal_count = nal_cnt_q;
    assign epb_count = epb_cnt_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nal_stream_parser.sv
// Directed bench for nal_stream_parser: two instances (default-ish with a 4-deep FIFO, and
// EPB pass-through with VPS/SPS/PPS filtered), byte-level driver, beat collector, scoreboard.
// Output beats are compared against hand-built expected lists.
module tb_nal_stream_parser;
    import nal_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  in_data   [2];
    logic        in_vld    [2];
    logic        in_last   [2];
    logic        in_rdy    [2];
    logic [7:0]  out_data  [2];
    logic        out_vld   [2];
    logic        out_rdy   [2];
    logic        out_sop   [2];
    logic        out_eop   [2];
    logic [5:0]  out_type  [2];
    logic [15:0] nal_count [2];
    logic [15:0] epb_count [2];
    logic        err       [2];
    logic        done      [2];

    nal_stream_parser #(
        .EPB_REMOVE (1'b1),
        .TYPE_MASK  (64'hFFFF_FFFF_FFFF_FFFF),
        .FIFO_DEPTH (4),
        .ZCNT_W     (8)
    ) dut_a (
        .clk (clk), .rst_n (rst_n),
        .in_data (in_data[0]), .in_vld (in_vld[0]), .in_last (in_last[0]), .in_rdy (in_rdy[0]),
        .out_data (out_data[0]), .out_vld (out_vld[0]), .out_rdy (out_rdy[0]),
        .out_sop (out_sop[0]), .out_eop (out_eop[0]), .out_type (out_type[0]),
        .nal_count (nal_count[0]), .epb_count (epb_count[0]), .err (err[0]), .done (done[0])
    );

    nal_stream_parser #(
        .EPB_REMOVE (1'b0),
        .TYPE_MASK  (64'hFFFF_FFF8_FFFF_FFFF),
        .FIFO_DEPTH (8),
        .ZCNT_W     (8)
    ) dut_b (
        .clk (clk), .rst_n (rst_n),
        .in_data (in_data[1]), .in_vld (in_vld[1]), .in_last (in_last[1]), .in_rdy (in_rdy[1]),
        .out_data (out_data[1]), .out_vld (out_vld[1]), .out_rdy (out_rdy[1]),
        .out_sop (out_sop[1]), .out_eop (out_eop[1]), .out_type (out_type[1]),
        .nal_count (nal_count[1]), .epb_count (epb_count[1]), .err (err[1]), .done (done[1])
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  stim_q [$];
    logic [15:0] exp_q  [$];
    logic [15:0] obs0_q [$];
    logic [15:0] obs1_q [$];
    int          done_cnt [2];
    int          hold_viol = 0;
    logic        stall_seen = 1'b0;
    logic [15:0] prev_beat  [2];
    logic        prev_stall [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] eb(input logic s, input logic e, input logic [5:0] t,
                                       input logic [7:0] b);
        return {s, e, t, b};
    endfunction

    // Beat collector, done counter and hold-stable monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] beat;
        for (int d = 0; d < 2; d++) begin
            beat = {out_sop[d], out_eop[d], out_type[d], out_data[d]};
            if (rst_n) begin
                if (prev_stall[d] && (!out_vld[d] || beat != prev_beat[d])) hold_viol++;
                if (out_vld[d] && out_rdy[d]) begin
                    if (d == 0) obs0_q.push_back(beat);
                    else        obs1_q.push_back(beat);
                end
                if (done[d]) done_cnt[d]++;
            end
            prev_stall[d] = rst_n && out_vld[d] && !out_rdy[d];
            prev_beat[d]  = beat;
        end
        if (rst_n && in_vld[0] && !in_rdy[0]) stall_seen = 1'b1;
    end

    task automatic send_byte(input int d, input logic [7:0] b, input logic last);
        int guard = 0;
        in_data[d] = b;
        in_vld[d]  = 1'b1;
        in_last[d] = last;
        @(negedge clk);
        while (!in_rdy[d] && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check_eq("in_rdy_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_vld[d]  = 1'b0;
        in_last[d] = 1'b0;
    endtask

    task automatic send_stim(input int d);
        for (int i = 0; i < stim_q.size(); i++) send_byte(d, stim_q[i], i == stim_q.size() - 1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        repeat (4) @(negedge clk);
        while (out_vld[d] && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check_eq("drain_timeout", n, 0);
    endtask

    task automatic check_out(input int d, input string tag);
        int n;
        n = (d == 0) ? obs0_q.size() : obs1_q.size();
        check_eq({tag, "_nbeats"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check_eq({tag, "_beat"}, (d == 0) ? obs0_q[i] : obs1_q[i], exp_q[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_vld[d]  = 1'b0;
            in_last[d] = 1'b0;
            in_data[d] = 8'h00;
            out_rdy[d] = 1'b1;
        end
        @(negedge clk);
        check_eq("rst_in_rdy_low", {in_rdy[0], in_rdy[1]}, 2'b00);
        obs0_q.delete();
        obs1_q.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_rdy_high", {in_rdy[0], in_rdy[1]}, 2'b11);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_outputs", {out_vld[d], out_sop[d], out_eop[d], out_type[d], err[d], done[d]}, 0);
            check_eq("rst_counts", {nal_count[d], epb_count[d]}, 0);
        end
    endtask

    task automatic load_test1();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'hAA,
                   8'h00, 8'h00, 8'h01, 8'h42, 8'h01, 8'hBB};
        exp_q.delete();
        exp_q.push_back(eb(1, 0, NAL_VPS, 8'h40));
        exp_q.push_back(eb(0, 0, NAL_VPS, 8'h01));
        exp_q.push_back(eb(0, 1, NAL_VPS, 8'hAA));
        exp_q.push_back(eb(1, 0, NAL_SPS, 8'h42));
        exp_q.push_back(eb(0, 0, NAL_SPS, 8'h01));
        exp_q.push_back(eb(0, 1, NAL_SPS, 8'hBB));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_vld[d] = 1'b0; in_last[d] = 1'b0; in_data[d] = 8'h00; out_rdy[d] = 1'b1;
            prev_stall[d] = 1'b0; prev_beat[d] = '0; done_cnt[d] = 0;
        end

        // Two back-to-back NALs, 3-byte start codes.
        do_reset();
        load_test1();
        send_stim(0);
        drain(0);
        check_out(0, "t1");
        check_eq("t1_nal_count", nal_count[0], 2);
        check_eq("t1_done_pulses", done_cnt[0], 1);
        check_eq("t1_epb_count", epb_count[0], 0);

        // Emulation prevention: removed on dut_a, passed through on dut_b.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'h00, 8'h00, 8'h03, 8'h01, 8'h7F};
        fork
            send_stim(0);
            send_stim(1);
        join
        drain(0);
        drain(1);
        exp_q.delete();
        exp_q.push_back(eb(1, 0, 6'd19, 8'h26));
        exp_q.push_back(eb(0, 0, 6'd19, 8'h01));
        exp_q.push_back(eb(0, 0, 6'd19, 8'h00));
        exp_q.push_back(eb(0, 0, 6'd19, 8'h00));
        exp_q.push_back(eb(0, 0, 6'd19, 8'h01));
        exp_q.push_back(eb(0, 1, 6'd19, 8'h7F));
        check_out(0, "t2_epb_on");
        check_eq("t2_epb_on_count", epb_count[0], 1);
        exp_q.insert(4, eb(0, 0, 6'd19, 8'h03));
        check_out(1, "t2_epb_off");
        check_eq("t2_epb_off_count", epb_count[1], 0);

        // 4-byte start code, single zero inside payload, trailing zeros dropped.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'hAA, 8'h00, 8'hBB,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'hCC};
        send_stim(0);
        drain(0);
        exp_q.delete();
        exp_q.push_back(eb(1, 0, 6'd1, 8'h02));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h01));
        exp_q.push_back(eb(0, 0, 6'd1, 8'hAA));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h00));
        exp_q.push_back(eb(0, 1, 6'd1, 8'hBB));
        exp_q.push_back(eb(1, 0, 6'd1, 8'h02));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h01));
        exp_q.push_back(eb(0, 1, 6'd1, 8'hCC));
        check_out(0, "t3");
        check_eq("t3_err", err[0], 0);
        check_eq("t3_nal_count", nal_count[0], 2);

        // Type filter drops VPS/SPS/PPS on dut_b.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'h0C,
                   8'h00, 8'h00, 8'h01, 8'h42, 8'h01, 8'h0D,
                   8'h00, 8'h00, 8'h01, 8'h44, 8'h01, 8'h0E,
                   8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'hAA};
        send_stim(1);
        drain(1);
        exp_q.delete();
        exp_q.push_back(eb(1, 0, 6'd1, 8'h02));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h01));
        exp_q.push_back(eb(0, 1, 6'd1, 8'hAA));
        check_out(1, "t4_filter");
        check_eq("t4_nal_count", nal_count[1], 1);
        check_eq("t4_done_pulses", done_cnt[1], 1);

        // Three zeros then a non-start byte flags err.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05};
        send_stim(1);
        drain(1);
        exp_q.delete();
        exp_q.push_back(eb(1, 0, 6'd1, 8'h02));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h01));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h00));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h00));
        exp_q.push_back(eb(0, 0, 6'd1, 8'h00));
        exp_q.push_back(eb(0, 1, 6'd1, 8'h05));
        check_out(1, "t5_err");
        check_eq("t5_err_flag", err[1], 1);

        // Header-only NAL, then in_last in SEARCH and in HDR.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h01, 8'h04, 8'h05};
        send_stim(0);
        stim_q = '{8'h00, 8'h00, 8'h01};
        send_stim(0);
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h06};
        send_stim(0);
        drain(0);
        exp_q.delete();
        exp_q.push_back(eb(1, 1, 6'd1, 8'h02));
        exp_q.push_back(eb(1, 0, 6'd2, 8'h04));
        exp_q.push_back(eb(0, 1, 6'd2, 8'h05));
        check_out(0, "t6_hdr_only");
        check_eq("t6_nal_count", nal_count[0], 2);
        check_eq("t6_done_pulses", done_cnt[0], 3);

        // Backpressure: output stalled 20 cycles during a 10-byte NAL on the 4-deep FIFO.
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13,
                   8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        stall_seen = 1'b0;
        out_rdy[0] = 1'b0;
        fork
            send_stim(0);
            begin
                repeat (20) @(posedge clk);
                #1;
                out_rdy[0] = 1'b1;
            end
        join
        drain(0);
        exp_q.delete();
        exp_q.push_back(eb(1, 0, 6'd1, 8'h02));
        for (int i = 0; i < 8; i++) exp_q.push_back(eb(0, 0, 6'd1, 8'h10 + 8'(i)));
        exp_q.push_back(eb(0, 1, 6'd1, 8'h18));
        check_eq("t7_in_rdy_fell", stall_seen, 1);
        check_out(0, "t7_backpressure");
        check_eq("t7_nal_count", nal_count[0], 1);

        // Reset mid-payload with beats still queued, then a clean rerun of the first stream.
        do_reset();
        out_rdy[0] = 1'b0;
        stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'hAA, 8'h02};
        for (int i = 0; i < stim_q.size(); i++) send_byte(0, stim_q[i], 1'b0);
        do_reset();
        load_test1();
        send_stim(0);
        drain(0);
        check_out(0, "t8_after_reset");
        check_eq("t8_nal_count", nal_count[0], 2);
        check_eq("t8_done_pulses", done_cnt[0], 1);

        check_eq("out_hold_stable", hold_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
